// File: rtl/memaccess.sv
// memaccess: RV32I MEM stage issuing data-memory requests and registering MEM/WB values.
module memaccess #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pipe_Valid,
  input  logic [31:0]       i_pipe_AluResult,
  input  logic [31:0]       i_pipe_StoreData,
  input  logic              i_pipe_MemRead,
  input  logic              i_pipe_MemWrite,
  input  logic [2:0]        i_pipe_Funct3,
  input  logic              i_pipe_MemToReg,
  input  logic              i_pipe_RegWrEn,
  input  logic [4:0]        i_pipe_RegDst,
  output logic              o_stall,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [31:0]       o_dmem_wdata,
  output logic [3:0]        o_dmem_wstrb,
  input  logic              i_dmem_ack,
  input  logic [31:0]       i_dmem_rdata,
  output logic [31:0]       o_pipe_MemData,
  output logic              o_pipe_MemToReg,
  output logic              o_pipe_RegWrEn,
  output logic [31:0]       o_pipe_AluResult,
  output logic [4:0]        o_pipe_RegDst,
  output logic              o_pipe_MemFault
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [2:0] f3_q;
  logic [1:0] off_q, off, sz;
  logic regwr_q, mem_op, bad_f3, misalign, fault;
  logic [7:0] lb;
  logic [15:0] lh;
  logic [31:0] load_data, st_data;
  logic [3:0] st_strb;
  always_comb begin
    off = i_pipe_AluResult[1:0];
    sz = i_pipe_Funct3[1:0];
    mem_op = i_pipe_Valid & (i_pipe_MemRead | i_pipe_MemWrite);
    bad_f3 = i_pipe_MemWrite ? (i_pipe_Funct3[2] | (sz == 2'b11))
                             : ((sz == 2'b11) | (i_pipe_Funct3 == 3'b110));
    misalign = ((sz == 2'b01) & off[0]) | ((sz == 2'b10) & (off != 2'b00));
    fault = (i_pipe_MemRead & i_pipe_MemWrite) | bad_f3 | misalign;
    o_stall = (state == IDLE) ? (mem_op & ~fault) : ~i_dmem_ack;
    st_data = sz[1] ? i_pipe_StoreData
            : sz[0] ? {2{i_pipe_StoreData[15:0]}} : {4{i_pipe_StoreData[7:0]}};
    st_strb = sz[1] ? 4'b1111 : sz[0] ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
    lb = i_dmem_rdata[{off_q, 3'b000} +: 8];
    lh = off_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    load_data = f3_q[1] ? i_dmem_rdata
              : f3_q[0] ? {{16{~f3_q[2] & lh[15]}}, lh} : {{24{~f3_q[2] & lb[7]}}, lb};
  end
  // Pass-through fields go straight to o_pipe_* at accept; only RegWrEn is held back as a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      f3_q <= '0;
      off_q <= '0;
      regwr_q <= 1'b0;
      o_dmem_req <= 1'b0;
      o_dmem_we <= 1'b0;
      o_dmem_addr <= '0;
      o_dmem_wdata <= '0;
      o_dmem_wstrb <= '0;
      o_pipe_MemData <= '0;
      o_pipe_MemToReg <= 1'b0;
      o_pipe_RegWrEn <= 1'b0;
      o_pipe_AluResult <= '0;
      o_pipe_RegDst <= '0;
      o_pipe_MemFault <= 1'b0;
    end else if (state == IDLE) begin
      o_pipe_AluResult <= i_pipe_AluResult;
      o_pipe_RegDst <= i_pipe_RegDst;
      o_pipe_MemToReg <= i_pipe_MemToReg;
      o_pipe_MemData <= '0;
      o_pipe_RegWrEn <= i_pipe_Valid & i_pipe_RegWrEn & ~mem_op;
      o_pipe_MemFault <= mem_op & fault;
      if (mem_op & ~fault) begin
        state <= BUSY;
        f3_q <= i_pipe_Funct3;
        off_q <= off;
        regwr_q <= i_pipe_RegWrEn;
        o_dmem_req <= 1'b1;
        o_dmem_we <= i_pipe_MemWrite;
        o_dmem_addr <= {i_pipe_AluResult[ADDR_W-1:2], 2'b00};
        o_dmem_wdata <= st_data;
        o_dmem_wstrb <= i_pipe_MemWrite ? st_strb : 4'b0000;
      end
    end else if (i_dmem_ack) begin
      state <= IDLE;
      o_dmem_req <= 1'b0;
      o_pipe_MemData <= o_dmem_we ? 32'd0 : load_data;
      o_pipe_RegWrEn <= regwr_q;
    end
  end
endmodule

// File: tb/tb_memaccess.sv
// tb_memaccess: directed plus randomized checks of memaccess against a transaction-level model.
module tb_memaccess;
  logic clk = 1'b0, reset;
  logic valid, mem_read, mem_write, mem_to_reg, reg_wr_en, ack;
  logic [31:0] alu, store_data, rdata;
  logic [2:0] funct3;
  logic [4:0] reg_dst;
  logic stall, req, we, p_m2r, p_rwe, p_fault;
  logic [31:0] addr, wdata, p_data, p_alu;
  logic [3:0] wstrb;
  logic [4:0] p_dst;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  memaccess #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_pipe_Valid(valid), .i_pipe_AluResult(alu), .i_pipe_StoreData(store_data),
    .i_pipe_MemRead(mem_read), .i_pipe_MemWrite(mem_write), .i_pipe_Funct3(funct3),
    .i_pipe_MemToReg(mem_to_reg), .i_pipe_RegWrEn(reg_wr_en), .i_pipe_RegDst(reg_dst),
    .o_stall(stall), .o_dmem_req(req), .o_dmem_we(we), .o_dmem_addr(addr),
    .o_dmem_wdata(wdata), .o_dmem_wstrb(wstrb), .i_dmem_ack(ack), .i_dmem_rdata(rdata),
    .o_pipe_MemData(p_data), .o_pipe_MemToReg(p_m2r), .o_pipe_RegWrEn(p_rwe),
    .o_pipe_AluResult(p_alu), .o_pipe_RegDst(p_dst), .o_pipe_MemFault(p_fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_fault(bit rd, bit wr, int f3, int a);
    int size = 1 << (f3 % 4);
    if (rd && wr) return 1;
    if (wr ? (f3 > 2) : (f3 == 3 || f3 > 5)) return 1;
    return (a % size) != 0;
  endfunction

  function automatic logic [31:0] load_val(int f3, int off, logic [31:0] word);
    logic [31:0] b = (word >> (8 * off)) & 32'hFF;
    logic [31:0] h = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      0: return b >= 128 ? b - 256 : b;
      1: return h >= 32768 ? h - 65536 : h;
      4: return b;
      5: return h;
      default: return word;
    endcase
  endfunction

  task automatic run_op(input bit v, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input bit m2r, input bit rwe,
                        input logic [4:0] dst, input int wait_n, input logic [31:0] rdat);
    bit mem_op = v && (rd || wr);
    bit flt = mem_op && is_fault(rd, wr, int'(f3), int'(a[1:0]));
    int size = 1 << (f3 % 4);
    logic [31:0] exp_wd = (f3 == 0) ? (d & 32'hFF) * 32'h01010101
                        : (f3 == 1) ? (d & 32'hFFFF) * 32'h00010001 : d;
    logic [31:0] exp_st = wr ? ((32'd1 << size) - 1) << a[1:0] : 32'd0;
    valid = v; mem_read = rd; mem_write = wr; funct3 = f3; alu = a; store_data = d;
    mem_to_reg = m2r; reg_wr_en = rwe; reg_dst = dst;
    @(negedge clk);
    chk("stall_accept", stall, mem_op && !flt);
    chk("req_idle", req, 0);
    @(posedge clk); #1;
    if (!mem_op || flt) begin
      chk("pt_alu", p_alu, a);
      chk("pt_dst", p_dst, dst);
      chk("pt_m2r", p_m2r, m2r);
      chk("pt_rwe", p_rwe, v && rwe && !mem_op);
      chk("pt_fault", p_fault, flt);
      chk("pt_data", p_data, 0);
      return;
    end
    chk("bubble_rwe", p_rwe, 0);
    valid = 1'($urandom); alu = $urandom; store_data = $urandom; funct3 = 3'($urandom);
    mem_read = 1'($urandom); mem_write = 1'($urandom);
    for (int k = 0; k <= wait_n; k++) begin
      if (k == wait_n) begin ack = 1'b1; rdata = rdat; end else rdata = $urandom;
      @(negedge clk);
      chk("busy_req", req, 1);
      chk("busy_we", we, wr);
      chk("busy_addr", addr, {a[31:2], 2'b00});
      if (wr) chk("busy_wdata", wdata, exp_wd);
      chk("busy_wstrb", wstrb, exp_st);
      chk("busy_stall", stall, k != wait_n);
      chk("busy_rwe", p_rwe, 0);
      @(posedge clk); #1;
    end
    ack = 1'b0; valid = 1'b0;
    chk("done_data", p_data, rd ? load_val(int'(f3), int'(a[1:0]), rdat) : 32'd0);
    chk("done_rwe", p_rwe, rwe);
    chk("done_alu", p_alu, a);
    chk("done_dst", p_dst, dst);
    chk("done_m2r", p_m2r, m2r);
    chk("done_fault", p_fault, 0);
    chk("done_req", req, 0);
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
    reg_wr_en = 1'b0; ack = 1'b0; alu = '0; store_data = '0; rdata = '0; funct3 = '0; reg_dst = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", req, 0);
    chk("rst_we", we, 0);
    chk("rst_wstrb", wstrb, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_pipe", {p_data ^ p_alu, 22'd0, p_dst, p_m2r, p_rwe, p_fault, stall}, 0);
    reset = 1'b0;
    run_op(1, 0, 0, 3'b000, 32'h1234, 0, 0, 1, 5, 0, 0);
    run_op(1, 1, 0, 3'b000, 32'h103, 0, 1, 1, 7, 1, 32'h80FF_0000);
    run_op(1, 1, 0, 3'b100, 32'h103, 0, 1, 1, 8, 1, 32'h80FF_0000);
    run_op(1, 0, 1, 3'b001, 32'h22, 32'hDEAD_BEEF, 0, 0, 0, 3, 0);
    run_op(1, 1, 0, 3'b010, 32'h41, 0, 1, 1, 9, 0, 0);
    run_op(1, 1, 0, 3'b010, 32'h40, 0, 1, 1, 10, 0, 32'h1234_5678);
    run_op(1, 1, 0, 3'b010, 32'h0, 0, 1, 1, 11, 0, 32'hAAAA_5555);
    run_op(1, 1, 0, 3'b010, 32'h4, 0, 1, 1, 12, 0, 32'h0BAD_F00D);
    run_op(1, 1, 1, 3'b000, 32'h10, 0, 1, 1, 13, 0, 0);
    // Reset in the second BUSY cycle of an SW, then a stale ack.
    valid = 1'b1; mem_write = 1'b1; mem_read = 1'b0; funct3 = 3'b010; alu = 32'h80;
    store_data = 32'hCAFE_F00D; reg_wr_en = 1'b1; reg_dst = 5'd3;
    @(posedge clk); #1;
    chk("rst_busy_req", req, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; valid = 1'b0; ack = 1'b1; rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rstb_req", req, 0);
    chk("rstb_stall", stall, 0);
    chk("rstb_pipe", {p_data | p_alu, 22'd0, p_dst, p_m2r, p_rwe, p_fault, we}, 0);
    @(posedge clk); #1;
    ack = 1'b0;
    chk("rstb_ack_rwe", p_rwe, 0);
    chk("rstb_ack_req", req, 0);
    chk("rstb_ack_data", p_data, 0);
    for (int i = 0; i < 300; i++) begin
      int op = $urandom_range(0, 7);
      run_op(($urandom % 8) != 0, op inside {1, 2, 7}, op inside {3, 4, 7},
             3'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), 5'($urandom),
             $urandom_range(0, 3), $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/memaccess.md
Name: memaccess

Overview:
Memory-access (MEM) stage of the light RV32I pipeline. It sits between execute and writeback.
- Issues loads and stores to the data memory over a req/ack handshake.
- Aligns and sign-extends load data.
- Registers the MEM/WB pipeline values consumed by writeback: MemData, MemToReg, RegWrEn, AluResult, RegDst.
- Stalls upstream stages while a memory transaction is outstanding.

Parameters:
- ADDR_W, 32, data-memory byte-address width (AluResult low ADDR_W bits used).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- i_pipe_Valid  in  1  EX/MEM slot holds a real instruction
- i_pipe_AluResult  in  32  effective address / ALU result
- i_pipe_StoreData  in  32  rs2 value for stores
- i_pipe_MemRead  in  1  load instruction
- i_pipe_MemWrite  in  1  store instruction
- i_pipe_Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_pipe_MemToReg  in  1  pass-through control
- i_pipe_RegWrEn  in  1  pass-through control
- i_pipe_RegDst  in  5  pass-through destination register
- o_stall  out  1  upstream must hold EX/MEM inputs stable
- o_dmem_req  out  1  memory request valid
- o_dmem_we  out  1  1 = write
- o_dmem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- o_dmem_wdata  out  32  lane-replicated store data
- o_dmem_wstrb  out  4  byte enables
- i_dmem_ack  in  1  transaction done; rdata valid same cycle for reads
- i_dmem_rdata  in  32  read word
- o_pipe_MemData  out  32  formatted load data
- o_pipe_MemToReg  out  1  to writeback
- o_pipe_RegWrEn  out  1  to writeback; 0 = bubble
- o_pipe_AluResult  out  32  to writeback
- o_pipe_RegDst  out  5  to writeback
- o_pipe_MemFault  out  1  misaligned or illegal-funct3 access in this slot

Behaviour:
- Reset: state IDLE. All o_pipe_* = 0. o_dmem_req/we/wstrb = 0. addr/wdata = 0. Reset during BUSY abandons the transaction: req is low after that edge, and a late ack is ignored.
- mem_op = i_pipe_Valid & (MemRead | MemWrite). MemRead & MemWrite both set is treated as illegal.
- Alignment:
  - H/HU requires addr[0]=0.
  - W requires addr[1:0]=0.
  - B/BU are always aligned.
  - Funct3 011/110/111 is illegal for loads; any funct3 other than 000/001/010 is illegal for stores.
- FSM IDLE:
  - Not mem_op: next edge registers pass-through values. o_pipe_RegWrEn = RegWrEn & Valid. o_pipe_MemData = 0. Latency 1, o_stall = 0.
  - mem_op with fault: no request issued. Next edge: o_pipe_MemFault = 1, o_pipe_RegWrEn = 0, o_stall = 0.
  - mem_op legal: o_stall = 1 combinationally. Next edge latches address, funct3, byte offset and pass-through fields, drives o_dmem_* registered, and moves to BUSY. o_pipe_RegWrEn = 0 that edge (bubble).
- FSM BUSY:
  - o_dmem_* held stable; inputs ignored.
  - o_stall = ~i_dmem_ack.
  - On ack: next edge writes the formatted result to o_pipe_*, deasserts req, and returns to IDLE.
  - In the ack cycle, upstream sees o_stall = 0 and advances. The new EX/MEM content is evaluated in IDLE on the following cycle.
  - Minimum load/store latency: 2 cycles from accept to o_pipe valid.
- Store formatting:
  - SB: wdata = {4{d[7:0]}}, wstrb = 0001 << off.
  - SH: wdata = {2{d[15:0]}}, wstrb = 0011 << (off[1]*2).
  - SW: wdata = d, wstrb = 1111.
  - Stores set o_pipe_MemData = 0.
- Load formatting (off = latched addr[1:0]):
  - Select byte lane off, or halfword lane off[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Read: we = 0, wstrb = 0.
- o_pipe_MemFault is 0 for every non-fault slot, including bubbles.

Test Plan:
- ALU op, AluResult=0x1234, RegDst=5, RegWrEn=1, no mem -> next cycle o_pipe_AluResult=0x1234, RegDst=5, RegWrEn=1; no req; o_stall=0 throughout.
- LB addr=0x103, ack 1 cycle after req, rdata=0x80FF_0000 -> dmem_addr=0x100, we=0; o_pipe_MemData=0xFFFF_FF80; stall exactly 2 cycles. LBU same -> 0x0000_0080.
- SH addr=0x22, StoreData=0xDEAD_BEEF, ack delayed 3 cycles -> wdata=0xBEEF_BEEF, wstrb=1100, req/addr stable all 3 wait cycles, o_stall high until the ack cycle.
- LW addr=0x41 -> no req, o_pipe_MemFault=1, o_pipe_RegWrEn=0, no stall; next legal op proceeds normally.
- Assert reset in the 2nd BUSY cycle of an SW, then raise ack -> req=0 after the reset edge, o_pipe_* all 0, FSM IDLE, ack ignored.
- Back-to-back LW 0x0 and LW 0x4, each acked immediately -> two requests separated by the IDLE accept cycle; MemData values delivered in order to o_pipe_*.
